// File: rtl/fetch_queue_ss_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and head-pair outputs.
// master = fetch queue, slave = memory/decode/control side.
interface fetch_queue_ss_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   imem_addr;
    logic [63:0]   imem_data;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   InstrD1;
    logic [31:0]   InstrD2;
    logic          valid1;
    logic          valid2;
    logic [31:0]   pcD;
    logic [CW-1:0] count;

    modport master (
        output imem_addr, InstrD1, InstrD2, valid1, valid2, pcD, count,
        input  imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, InstrD1, InstrD2, valid1, valid2, pcD, count,
        output imem_data, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_ss.sv
// Dual-issue fetch stage: owns the fetch PC and buffers fetched
// instruction pairs in a small FIFO ahead of the two decode lanes.
module fetch_queue_ss #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic             clk,
    input logic             reset,
    fetch_queue_ss_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] slot1;
        logic [31:0] slot0;
        logic [31:0] pairPc;
        logic        v1;
        logic        v0;
    } entry_t;

    entry_t        q [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] cnt;
    logic [31:0]   fpc;
    logic [31:0]   pairAddr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    entry_t        head;

    assign pairAddr = fpc & ~32'h7;
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign pop      = ~bus.stall & ~empty;
    // A full queue still accepts a pair when the head leaves this cycle.
    assign push     = ~bus.redirect & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc   <= RESET_PC;
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else if (bus.redirect) begin
            fpc   <= bus.redirect_pc & ~32'h3;
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
                fpc   <= pairAddr + 32'd8;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q[wrPtr] <= '{
                slot1:  bus.imem_data[63:32],
                slot0:  bus.imem_data[31:0],
                pairPc: pairAddr,
                v1:     1'b1,
                v0:     ~fpc[2]
            };
        end
    end

    assign head = q[rdPtr];

    assign bus.imem_addr = pairAddr;
    assign bus.count     = cnt;
    assign bus.valid1    = ~empty & head.v0;
    assign bus.valid2    = ~empty & head.v1;
    assign bus.InstrD1   = (~empty & head.v0) ? head.slot0 : 32'h0;
    assign bus.InstrD2   = (~empty & head.v1) ? head.slot1 : 32'h0;
    assign bus.pcD       = empty ? 32'h0 : head.pairPc;
endmodule
